// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader sits on the slave side; the stream source / memory model uses master.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_reset;
  logic                  done;
  logic                  error;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a MAGIC/length/data/checksum byte frame, writes
// little-endian words to instruction memory and releases the core once verified.
module imem_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] HDR_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state;
  logic [7:0]            n_lo;
  logic [15:0]           n_words;
  logic [1:0]            byte_cnt;
  logic [15:0]           word_cnt;
  logic [7:0]            csum;
  logic [23:0]           word_buf;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  in_ready;
  logic                  accept;
  logic [15:0]           n_hdr;

  // The loader never stalls the stream, so ready is simply held high.
  assign in_ready = 1'b1;
  assign accept   = bus.in_valid && in_ready;
  assign n_hdr    = {bus.in_data, n_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      n_lo         <= 8'd0;
      n_words      <= 16'd0;
      byte_cnt     <= 2'd0;
      word_cnt     <= 16'd0;
      csum         <= 8'd0;
      word_buf     <= 24'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
    end else begin
      imem_we_q <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (bus.in_data == MAGIC) begin
              state    <= HDR_LO;
              csum     <= 8'd0;
              byte_cnt <= 2'd0;
              word_cnt <= 16'd0;
            end
          end
          HDR_LO: begin
            n_lo  <= bus.in_data;
            state <= HDR_HI;
          end
          HDR_HI: begin
            n_words <= n_hdr;
            if ({1'b0, n_hdr} > CAPACITY)
              state <= ERROR;
            else if (n_hdr == 16'd0)
              state <= CHECK;
            else
              state <= DATA;
          end
          DATA: begin
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= bus.in_data;
              2'd1: word_buf[15:8]  <= bus.in_data;
              2'd2: word_buf[23:16] <= bus.in_data;
              2'd3: begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= word_cnt[ADDR_WIDTH-1:0];
                imem_wdata_q <= {bus.in_data, word_buf};
                word_cnt     <= word_cnt + 16'd1;
                // The final word hands over to checksum; the counter never wraps into another write.
                if (word_cnt == n_words - 16'd1)
                  state <= CHECK;
              end
            endcase
          end
          CHECK: state <= (bus.in_data == csum) ? DONE : ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_reset = (state != DONE);
  assign bus.done       = (state == DONE);
  assign bus.error      = (state == ERROR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the single-cycle core. It accepts a framed byte stream on a valid/ready interface, assembles little-endian 32-bit words and writes them to consecutive instruction-memory word addresses. It verifies a checksum and holds the core in reset until a complete, valid image has been written.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; a transfer occurs on a clk edge with in_valid && in_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  word to write
- core_reset  out  1  holds the core (PC and register file) in reset
- done  out  1  valid image loaded
- error  out  1  frame rejected

## Operation
- Frame format: MAGIC, N[7:0], N[15:8], then 4*N data bytes (word k is bytes b0..b3, with imem_wdata = {b3,b2,b1,b0}), then a checksum byte equal to the XOR of all 4*N data bytes.
- States:
  - IDLE: bytes other than MAGIC are dropped; MAGIC goes to HDR_LO.
  - HDR_LO: latch N[7:0], go to HDR_HI.
  - HDR_HI: latch N[15:8].
    - N > 2^ADDR_WIDTH goes to ERROR.
    - N == 0 goes to CHECK.
    - Otherwise go to DATA.
  - DATA: a 2-bit byte counter and a word counter advance; the 4th byte of a word triggers the write. After word N-1 is written, go to CHECK.
  - CHECK: the checksum byte equal to the running XOR goes to DONE; otherwise go to ERROR.
  - DONE: MAGIC restarts at HDR_LO; other bytes are dropped.
  - ERROR: MAGIC restarts at HDR_LO; other bytes are dropped.
- The running XOR, byte counter and word address clear on every accepted MAGIC.
- in_ready = 1 in all states. It is a function of the state register only and never depends on in_valid.
- core_reset = 0 only in DONE; it is 1 in every other state. A restart from DONE reasserts it on the next cycle.
- done = 1 only in DONE. error = 1 only in ERROR.
- Writes to word addresses below those already written during an aborted frame are not undone. Memory contents after ERROR are unspecified.

## Timing
- Reset values: in_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, done 0, error 0. The state is IDLE and all counters are 0.
- Write latency: imem_we is registered. It is high for exactly one cycle, in the cycle after the edge that accepts byte b3. imem_addr and imem_wdata are valid in that same cycle and hold their values until the next write.
- imem_addr for word k equals k. The address is ADDR_WIDTH bits wide, so with N == 2^ADDR_WIDTH the last write is at address 2^ADDR_WIDTH-1 and the counter does not wrap to a further write.
- State transitions happen on the edge that accepts the byte.
  - done rises in the cycle after the checksum byte is accepted.
  - error rises in the cycle after the offending byte is accepted.
  - core_reset falls in the same cycle as done rises.
- An idle in_valid (gaps or stalls) holds all state. There is no timeout.
- Asserting reset at any point, including mid-frame, returns the block asynchronously to IDLE with all reset values; no further writes occur.
- The throughput is one byte per cycle with no bubbles between frames.

## Test plan
- Two-word load: send A5, 02, 00, 13 05 A0 00, 93 05 B0 00, checksum 00^...=XOR of the 8 bytes. Required: writes addr0=0x00A00513 and addr1=0x00B00593, one cycle each; done=1; core_reset=0; error=0.
- Checksum mismatch: the same frame with checksum byte XOR 0x01. Required: both writes occur; error=1; done=0; core_reset stays 1.
- Empty and oversized frames: A5 00 00 00 gives done=1 with no imem_we. A5 01 01 with ADDR_WIDTH=8 (N=257) gives error=1 immediately after the third byte.
- Noise and backpressure: send 00 FF before A5, then a valid one-word frame with random in_valid gaps of 0-5 cycles. Required: the leading bytes are ignored; exactly one write to addr 0; done=1.
- Reset mid-frame: assert reset after the 6th byte of the two-word frame. Required: all outputs at reset values asynchronously; no write was issued for word 0; a subsequent full frame loads correctly.
- Restart after DONE: after a successful load, send a new one-word frame. Required: core_reset=1 from the cycle after the A5 byte until the new done; new word at addr 0.
